debounce_multi: RTL

Parametrised multi-channel successor to the single-button debouncer. It synchronises N_CH raw button or switch inputs and filters each one against a shared, programmable sample tick. Per channel it produces a clean level, one-clock press and release pulses, and a one-shot long-press pulse. It sits between the board pins and the watch mode/set FSMs. It replaces per-button debouncer instances.

---
 rtl/debounce_multi.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/debounce_multi.sv
// debounce_multi
//   Multi-channel button/switch debouncer. Each raw input is brought into the
//   clk domain through a two-flop synchroniser, polarity-corrected, then
//   filtered against a shared sample tick. A channel's clean level only
//   changes after STABLE_TICKS consecutive ticks disagree with it. Edge pulses
//   and a one-shot long-press pulse are derived from the clean level.
//
// Parameters
//   N_CH         number of independent channels (>=1)
//   CLK_DIV      clk cycles per sample tick (>=2)
//   STABLE_TICKS consecutive disagreeing ticks before key changes (>=1)
//   LONG_TICKS   ticks key must stay high before key_long fires (>=1)
//   ACTIVE_LOW   1 = raw inputs are active-low
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active low
//   btn          raw asynchronous button inputs
//   key          debounced level, 1 = pressed
//   key_press    one-clk pulse on key 0->1
//   key_release  one-clk pulse on key 1->0
//   key_long     one-clk pulse once per press after LONG_TICKS ticks held
//   tick         one-clk sample strobe, period CLK_DIV
module debounce_multi #(
  parameter int N_CH         = 4,
  parameter int CLK_DIV      = 50000,
  parameter int STABLE_TICKS = 30,
  parameter int LONG_TICKS   = 1000,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] key,
  output logic [N_CH-1:0] key_press,
  output logic [N_CH-1:0] key_release,
  output logic [N_CH-1:0] key_long,
  output logic            tick
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int STAB_W = $clog2(STABLE_TICKS + 1);
  localparam int HOLD_W = $clog2(LONG_TICKS + 1);

  localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(CLK_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_TICKS - 1);
  localparam logic [HOLD_W-1:0] LONG_MAX  = HOLD_W'(LONG_TICKS);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_TICKS - 1);

  // Released level of the raw pins, so the synchroniser powers up "not pressed".
  localparam logic [N_CH-1:0] REL_LEVEL = {N_CH{ACTIVE_LOW != 0}};

  logic [DIV_W-1:0]  div_q, div_d;
  logic              tick_q, tick_d;
  logic [N_CH-1:0]   sync1_q, sync1_d;
  logic [N_CH-1:0]   sync2_q, sync2_d;
  logic [N_CH-1:0]   btn_s;
  logic [N_CH-1:0]   key_q, key_d;
  logic [N_CH-1:0]   key_prev_q, key_prev_d;
  logic [N_CH-1:0]   press_q, press_d;
  logic [N_CH-1:0]   release_q, release_d;
  logic [N_CH-1:0]   long_q, long_d;
  logic [STAB_W-1:0] stab_q [N_CH];
  logic [STAB_W-1:0] stab_d [N_CH];
  logic [HOLD_W-1:0] hold_q [N_CH];
  logic [HOLD_W-1:0] hold_d [N_CH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q      <= '0;
      tick_q     <= 1'b0;
      sync1_q    <= REL_LEVEL;
      sync2_q    <= REL_LEVEL;
      key_q      <= '0;
      key_prev_q <= '0;
      press_q    <= '0;
      release_q  <= '0;
      long_q     <= '0;
      for (int i = 0; i < N_CH; i++) begin
        stab_q[i] <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      div_q      <= div_d;
      tick_q     <= tick_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      key_q      <= key_d;
      key_prev_q <= key_prev_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      for (int i = 0; i < N_CH; i++) begin
        stab_q[i] <= stab_d[i];
        hold_q[i] <= hold_d[i];
      end
    end
  end

  always_comb begin
    // Shared tick: registered strobe in the cycle after the divider wraps.
    div_d  = (div_q == DIV_MAX) ? '0 : div_q + DIV_W'(1);
    tick_d = (div_q == DIV_MAX);

    sync1_d = btn;
    sync2_d = sync1_q;
    btn_s   = sync2_q ^ REL_LEVEL;

    key_d  = key_q;
    long_d = '0;
    stab_d = stab_q;
    hold_d = hold_q;

    for (int i = 0; i < N_CH; i++) begin
      // Any agreeing sample restarts qualification, so short bounces never
      // reach the threshold.
      if (tick_q) begin
        if (btn_s[i] == key_q[i]) begin
          stab_d[i] = '0;
        end else if (stab_q[i] == STAB_LAST) begin
          key_d[i]  = btn_s[i];
          stab_d[i] = '0;
        end else begin
          stab_d[i] = stab_q[i] + STAB_W'(1);
        end
      end

      // hold_cnt saturates at LONG_TICKS so key_long fires once per press.
      if (!key_q[i]) begin
        hold_d[i] = '0;
      end else if (tick_q && (hold_q[i] < LONG_MAX)) begin
        hold_d[i] = hold_q[i] + HOLD_W'(1);
        if (hold_q[i] == LONG_LAST) begin
          long_d[i] = 1'b1;
        end
      end
    end

    key_prev_d = key_q;
    press_d    = key_q & ~key_prev_q;
    release_d  = ~key_q & key_prev_q;
  end

  assign key         = key_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;
  assign tick        = tick_q;

endmodule
